// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants, colour types and the control word
// that travels down the scan-out pipeline alongside the RAM read.
package vga_pkg;

   localparam int VGA_H_VIS  = 800;
   localparam int VGA_H_FP   = 40;
   localparam int VGA_H_SYNC = 128;
   localparam int VGA_H_BP   = 88;
   localparam int VGA_V_VIS  = 600;
   localparam int VGA_V_FP   = 1;
   localparam int VGA_V_SYNC = 4;
   localparam int VGA_V_BP   = 23;

   localparam int H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int H_CNT_W = 11;
   localparam int V_CNT_W = 10;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   typedef struct packed {
      logic       visible;
      logic       hsync;
      logic       vsync;
      logic       first;
      logic       tp;
      logic [2:0] bar;
   } scan_ctrl_t;

   // Nibble replication maps 0x0 to 0x00 and 0xF to 0xFF exactly.
   function automatic rgb888_t expand_rgb(input rgb444_t c);
      return '{r: {c.r, c.r}, g: {c.g, c.g}, b: {c.b, c.b}};
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with sync, visible flag and line/frame strobes,
// all valid in the same cycle as the counters (stage 0).
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VIS  = VGA_H_VIS,
   parameter int H_FP   = VGA_H_FP,
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP   = VGA_H_BP,
   parameter int V_VIS  = VGA_V_VIS,
   parameter int V_FP   = VGA_V_FP,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP   = VGA_V_BP
) (
   input  logic       clock,
   input  logic       reset,
   output logic       visible,
   output logic       hsync_act,
   output logic       vsync_act,
   output logic       line_end,
   output logic       frame_end,
   output logic       frame_first,
   output logic [2:0] h_bar
);

   localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(HT - 1);
   localparam logic [H_CNT_W-1:0] H_VIS_END  = H_CNT_W'(H_VIS);
   localparam logic [H_CNT_W-1:0] H_VIS_LAST = H_CNT_W'(H_VIS - 1);
   localparam logic [H_CNT_W-1:0] HS_START   = H_CNT_W'(H_VIS + H_FP);
   localparam logic [H_CNT_W-1:0] HS_END     = H_CNT_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(VT - 1);
   localparam logic [V_CNT_W-1:0] V_VIS_END  = V_CNT_W'(V_VIS);
   localparam logic [V_CNT_W-1:0] VS_START   = V_CNT_W'(V_VIS + V_FP);
   localparam logic [V_CNT_W-1:0] VS_END     = V_CNT_W'(V_VIS + V_FP + V_SYNC);

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign visible     = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
   assign hsync_act   = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vsync_act   = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign line_end    = (h_cnt == H_VIS_LAST) && (v_cnt < V_VIS_END);
   assign frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign frame_first = (h_cnt == '0) && (v_cnt == '0);
   // 128-pixel colour bars; bar 7 starts at 896 and never reaches the screen.
   assign h_bar       = h_cnt[9:7];

endmodule

// File: rtl/vga_fb_scanout.sv
// Frame-buffer reader: replicated read-address generation plus a RAM_LAT+1 deep
// pipeline that keeps colour, sync and blank aligned to the block-RAM latency.
module vga_fb_scanout
   import vga_pkg::*;
#(
   parameter int H_VIS    = VGA_H_VIS,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_VIS    = VGA_V_VIS,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b1,
   parameter int SCALE    = 4,
   parameter int FB_W     = 200,
   parameter int FB_H     = 150,
   parameter int ADDR_W   = 18,
   parameter int RAM_LAT  = 1
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   input  logic              test_pattern,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic              vga_blank_n,
   output logic              frame_start
);

   localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SCALE - 1);
   localparam logic [ADDR_W-1:0] FB_STRIDE = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((FB_H - 1) * FB_W);

   logic       visible;
   logic       hsync_act;
   logic       vsync_act;
   logic       line_end;
   logic       frame_end;
   logic       frame_first;
   logic [2:0] h_bar;

   vga_timing_gen #(
      .H_VIS  (H_VIS),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_VIS  (V_VIS),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP)
   ) u_timing (
      .clock       (clock),
      .reset       (reset),
      .visible     (visible),
      .hsync_act   (hsync_act),
      .vsync_act   (vsync_act),
      .line_end    (line_end),
      .frame_end   (frame_end),
      .frame_first (frame_first),
      .h_bar       (h_bar)
   );

   logic [SUB_W-1:0]  sub_x;
   logic [SUB_W-1:0]  sub_y;
   logic [ADDR_W-1:0] line_base;

   // rd_addr always holds the address of the pixel the counters point at, so
   // replication is done with adds and reloads instead of a multiplier. After
   // the last buffer line the address parks until the frame wraps.
   always_ff @(posedge clock) begin
      if (reset || frame_end) begin
         sub_x     <= '0;
         sub_y     <= '0;
         line_base <= '0;
         rd_addr   <= '0;
      end else if (visible) begin
         if (line_end) begin
            sub_x <= '0;
            if (sub_y == SUB_LAST) begin
               sub_y <= '0;
               if (line_base != LAST_BASE) begin
                  line_base <= line_base + FB_STRIDE;
                  rd_addr   <= line_base + FB_STRIDE;
               end
            end else begin
               sub_y   <= sub_y + 1'b1;
               rd_addr <= line_base;
            end
         end else if (sub_x == SUB_LAST) begin
            sub_x   <= '0;
            rd_addr <= rd_addr + 1'b1;
         end else begin
            sub_x <= sub_x + 1'b1;
         end
      end
   end

   scan_ctrl_t stage0;
   scan_ctrl_t pipe [RAM_LAT];
   scan_ctrl_t cur;
   rgb888_t    pix;

   assign stage0 = '{visible: visible, hsync: hsync_act, vsync: vsync_act,
                     first: frame_first, tp: test_pattern, bar: h_bar};
   assign cur    = pipe[RAM_LAT-1];

   // Control rides alongside the RAM read so it meets rd_data in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RAM_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= stage0;
         for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      pix = expand_rgb(rgb444_t'(rd_data));
      if (cur.tp) begin
         pix = '{r: {8{cur.bar[2]}}, g: {8{cur.bar[1]}}, b: {8{cur.bar[0]}}};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hsync   <= ~SYNC_POL;
         vga_vsync   <= ~SYNC_POL;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_r       <= cur.visible ? pix.r : 8'h00;
         vga_g       <= cur.visible ? pix.g : 8'h00;
         vga_b       <= cur.visible ? pix.b : 8'h00;
         vga_hsync   <= cur.hsync ? SYNC_POL : ~SYNC_POL;
         vga_vsync   <= cur.vsync ? SYNC_POL : ~SYNC_POL;
         vga_blank_n <= cur.visible;
         frame_start <= cur.first;
      end
   end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Scans a frame buffer out to the VGA DAC. It is the reader side of the BlockRam frame buffer that the capture path writes.
- Generates its own 800x600@60 timing on the 40 MHz PLL clock and issues sequential block-RAM read addresses, with pixel and line replication.
- Drives 8-bit R/G/B, sync and blank, all aligned to the RAM read latency.
- Sits between BlockRam (read port) and the VGA_* board outputs.

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch (line total 1056)
- V_VIS, 600, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch (frame total 628)
- SYNC_POL, 1, active level of hsync/vsync
- SCALE, 4, replication factor in both axes
- FB_W, 200, frame-buffer width in pixels (H_VIS/SCALE)
- FB_H, 150, frame-buffer height in lines (V_VIS/SCALE)
- ADDR_W, 18, RAM address width
- RAM_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
- clock, in, 1, pixel clock (40 MHz PLL output)
- reset, in, 1, synchronous, active-high
- rd_addr, out, ADDR_W, frame-buffer read address
- rd_data, in, 12, RAM q as {R[3:0],G[3:0],B[3:0]}, valid RAM_LAT cycles after rd_addr
- test_pattern, in, 1, replace RAM data with 8 vertical colour bars
- vga_r / vga_g / vga_b, out, 8 each, colour outputs
- vga_hsync, out, 1, horizontal sync
- vga_vsync, out, 1, vertical sync
- vga_blank_n, out, 1, high during the visible region
- frame_start, out, 1, one-cycle pulse at pixel (0,0) of the counter stage

Behaviour:
- Reset values: h_cnt=0, v_cnt=0, rd_addr=0, rgb=0, hsync=vsync=~SYNC_POL, blank_n=0, frame_start=0. The delay pipeline is cleared the same way.
- Reset mid-frame restarts timing at (0,0) on the cycle after reset is released.
- Stage 0 counters:
  - h_cnt counts 0..1055 and wraps to 0.
  - v_cnt increments when h_cnt wraps, counting 0..627, then wraps to 0.
- Stage 0 derived signals:
  - visible = h_cnt<H_VIS && v_cnt<V_VIS.
  - hsync active when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC.
  - vsync active likewise on v_cnt with the vertical parameters.
- Address generation (no multiplier):
  - sub_x counts 0..SCALE-1 over visible pixels; rd_addr increments when sub_x wraps.
  - line_base holds the address of the current buffer line.
  - At the end of each visible line, sub_y increments. If sub_y wraps (SCALE lines done), line_base += FB_W; otherwise rd_addr reloads line_base, so the line repeats.
  - At v_cnt wrap: line_base=0, rd_addr=0, sub_x=sub_y=0.
  - Outside the visible region rd_addr holds its value.
  - Last read address of a frame is FB_W*FB_H-1 (29999); it never exceeds this.
- Alignment:
  - visible, hsync and vsync pass through a shift register of depth RAM_LAT+1.
  - Outputs for counter position (c,r) appear exactly RAM_LAT+1 cycles after the counters hold (c,r). Sync and colour stay mutually aligned.
- Colour:
  - Each 4-bit channel n expands to 8 bits as {n,n}, so 0xF gives 0xFF and 0x0 gives 0x00.
  - When delayed-visible=0, rgb is forced to 0 regardless of rd_data.
- Test pattern:
  - Bar index = h_cnt[9:7] (bars 128 px wide; index 7 never visible).
  - Index bit2 drives R, bit1 drives G, bit0 drives B, each at 0xFF or 0x00.
  - The test pattern takes the same pipeline path as RAM data.
  - test_pattern is sampled in stage 0 and may change mid-line; the effect is per pixel.
- frame_start: asserted in the output stage together with the first visible pixel of the frame.

Decomposition:
- Package vga_pkg:
  - 800x600 timing constants and the H_TOTAL/V_TOTAL localparams.
  - rgb444 type and the rgb444-to-rgb888 expansion function.
- Sub-module vga_timing_gen:
  - Contains the h/v counters, sync generation, visible flag and end-of-line/end-of-frame strobes.
  - vga_fb_scanout instantiates it and adds address generation and the alignment pipeline.

Test Plan:
- Release reset, run 1 frame -> hsync period 1056 cycles, active for 128 cycles starting at h=840; vsync active 4 lines starting at v=601; 1056*628=663168 cycles per frame.
- RAM model with RAM_LAT=1 and data=address[11:0] -> first visible output at cycle 2 after (0,0); pixels 0..3 all show address 0, pixel 4 shows address 1; line 1 repeats line 0's addresses; line 4 starts at address 200.
- Full frame -> maximum rd_addr observed is 29999; rd_addr returns to 0 at the next frame start; frame_start pulses once per 663168 cycles.
- rd_data=12'hF0A in the visible region -> rgb = FF/00/AA; during blanking with the same data -> rgb 0 and blank_n=0.
- test_pattern=1 -> pixel 0 = 000000, pixel 128 = 0000FF, pixel 640 = FF00FF.
- Assert reset at h=500, v=300 for 3 cycles -> outputs go to reset values; after release, counters restart at (0,0) and sync timing from case 1 holds; repeat with RAM_LAT=2 -> latency 3.
